stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-cycle controller for CALL, RET, RTI and hardware interrupt entry in the 8-bit EL3030 pipeline. It owns the stack pointer and drives the data-memory port and the PC/flag load paths that the single-cycle execution stage cannot drive on its own. While a sequence runs it stalls fetch/decode. It returns control to the pipeline once the new PC, and the restored flags for RTI, have been loaded.

## Interface
Parameters:
- SP_RESET, 8'hFF, stack pointer value after reset; the stack grows downward.
- INT_VECTOR, 8'h01, memory address holding the interrupt service routine start address.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- INTR  in  1  interrupt request line; level input, sampled every cycle
- Call_Req  in  1  CALL in EX; valid for one cycle
- Ret_Req  in  1  RET in EX; valid for one cycle
- Rti_Req  in  1  RTI in EX; valid for one cycle
- Call_Target  in  8  CALL destination address, valid with Call_Req
- PC_Next  in  8  address the fetch stage would use next; return address to push
- Flags  in  4  current CCR {V,C,N,Z}
- Mem_Rdata  in  8  data memory read data; valid the cycle after Mem_Rd
- Mem_Addr  out  8  data memory address
- Mem_Wdata  out  8  data memory write data
- Mem_Rd  out  1  data memory read strobe
- Mem_Wr  out  1  data memory write strobe
- PC_Load  out  1  load PC_Value into PC this cycle
- PC_Value  out  8  new PC
- Flags_Load  out  1  load Flags_Value into CCR; drives MEM_Stack_Flags
- Flags_Value  out  4  restored flags; drives Flags_From_Memory
- Stall  out  1  freeze fetch/decode/EX
- Int_Ack  out  1  one-cycle pulse when an interrupt is accepted
- SP_Value  out  8  current stack pointer
- Stack_Err  out  1  sticky stack wrap error

## Operation
- States: IDLE, CALL_PUSH, INT_PUSH_PC, INT_PUSH_FL, INT_VEC_RD, INT_VEC_LD, POP_FL_RD, POP_PC_RD, POP_PC_LD.
- Int_Pend register: set on an INTR level when not already set; cleared when an interrupt is accepted.
- Push: Mem_Wr=1, Mem_Addr=SP, then SP←SP−1.
- Pop read: Mem_Rd=1, Mem_Addr=SP+1 (8-bit wrap), then SP←SP+1.
- IDLE acceptance priority: Rti_Req, then Ret_Req, then Call_Req, then Int_Pend.
  - An instruction request always completes before a pending interrupt is taken.
  - Only one request is accepted per IDLE cycle.
  - Requests arriving in non-IDLE states are ignored; the pipeline is stalled, so none are legal then.
- Call_Req → CALL_PUSH:
  - pushes the latched PC_Next (return address);
  - PC_Load=1 with the latched Call_Target;
  - then IDLE.
- Int_Pend → Int_Ack=1 and PC_Next is latched, then:
  - INT_PUSH_PC: push PC_Next.
  - INT_PUSH_FL: push {4'b0,Flags}.
  - INT_VEC_RD: Mem_Rd=1, Mem_Addr=INT_VECTOR; SP unchanged.
  - INT_VEC_LD: PC_Load=1, PC_Value=Mem_Rdata; then IDLE.
- Rti_Req:
  - POP_FL_RD: pop read.
  - POP_PC_RD: pop read; Flags_Load=1, Flags_Value=Mem_Rdata[3:0].
  - POP_PC_LD: PC_Load=1, PC_Value=Mem_Rdata; then IDLE.
- Ret_Req: enters POP_PC_RD directly, with Flags_Load forced to 0 there, then POP_PC_LD.
- Stack_Err:
  - set by a push at SP==8'h00 (SP wraps to 8'hFF);
  - set by a pop at SP==8'hFF (SP wraps to 8'h00);
  - the operation still proceeds;
  - cleared only by reset.
- All strobes and data outputs are Moore-decoded from the state and latch registers. Exceptions:
  - Stall is also asserted combinationally in the IDLE cycle that accepts a request.
  - Int_Ack is asserted combinationally in that same IDLE cycle.
- Outputs not driven by the current state are 0.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state←IDLE, SP←SP_RESET, Int_Pend←0, Stack_Err←0;
  - all outputs 0 except SP_Value=SP_RESET;
  - a sequence in progress is abandoned with no further memory strobes.
- Stall-high cycles, counting the IDLE accept cycle:
  - CALL: 2
  - RET: 3
  - RTI: 4
  - interrupt: 5
- Stall deasserts in the cycle after the PC_Load cycle.
- PC_Load and Flags_Load are single-cycle pulses.
- Memory read latency is fixed at 1 cycle; no wait states.
- Back-to-back: an interrupt pending during a sequence is accepted in the first IDLE cycle after that sequence.
- INTR held high across an interrupt acceptance re-sets Int_Pend on the next cycle. Software/peripheral must deassert INTR within the ISR.

## Test plan
- Reset, then CALL with SP=FF, PC_Next=0x10, Call_Target=0x40:
  - mem[FF]←0x10, PC_Load with 0x40, SP=FE;
  - Stall high exactly 2 cycles.
- RET after that CALL: read at 0xFF, PC_Load 0x10, SP=FF, Flags_Load never asserted.
- Interrupt with PC_Next=0x22, Flags=4'b1010, mem[01]=0x80:
  - Int_Ack pulse;
  - mem[FF]=0x22, mem[FE]=0x0A;
  - PC_Load 0x80, SP=FD, 5 stall cycles.
- RTI from that interrupt: Flags_Load with 4'b1010, then PC_Load 0x22, SP=FF.
- INTR and Call_Req in the same IDLE cycle: CALL completes first; Int_Ack on the next IDLE cycle, pushing the Call_Target as return PC.
- Push at SP=00 sets Stack_Err and SP=FF. rst_n=0 during INT_PUSH_FL: next cycle IDLE, SP=FF, no Mem_Wr/Mem_Rd.

Source files
------------

// File: rtl/stack_sequencer.sv
// Multi-cycle CALL / RET / RTI / interrupt-entry sequencer for the EL3030 pipeline.
// Owns the stack pointer and drives the data-memory, PC-load and flag-load paths while stalling the pipe.
module stack_sequencer #(
   parameter logic [7:0] SP_RESET   = 8'hFF,
   parameter logic [7:0] INT_VECTOR = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       INTR,
   input  logic       Call_Req,
   input  logic       Ret_Req,
   input  logic       Rti_Req,
   input  logic [7:0] Call_Target,
   input  logic [7:0] PC_Next,
   input  logic [3:0] Flags,
   input  logic [7:0] Mem_Rdata,
   output logic [7:0] Mem_Addr,
   output logic [7:0] Mem_Wdata,
   output logic       Mem_Rd,
   output logic       Mem_Wr,
   output logic       PC_Load,
   output logic [7:0] PC_Value,
   output logic       Flags_Load,
   output logic [3:0] Flags_Value,
   output logic       Stall,
   output logic       Int_Ack,
   output logic [7:0] SP_Value,
   output logic       Stack_Err
);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      CALL_PUSH   = 4'd1,
      INT_PUSH_PC = 4'd2,
      INT_PUSH_FL = 4'd3,
      INT_VEC_RD  = 4'd4,
      INT_VEC_LD  = 4'd5,
      POP_FL_RD   = 4'd6,
      POP_PC_RD   = 4'd7,
      POP_PC_LD   = 4'd8
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] sp_q, sp_d;
   logic [7:0] pc_lat_q, pc_lat_d;
   logic [7:0] tgt_q, tgt_d;
   logic       rti_q, rti_d;
   logic       int_pend_q, int_pend_d;
   logic       err_q, err_d;

   logic       is_idle_c;
   logic       instr_req_c;
   logic       accept_c;
   logic       accept_int_c;

   // Instruction requests win over a pending interrupt; nothing is accepted while in reset.
   assign is_idle_c    = (state_q == IDLE);
   assign instr_req_c  = Rti_Req | Ret_Req | Call_Req;
   assign accept_c     = rst_n & is_idle_c & (instr_req_c | int_pend_q);
   assign accept_int_c = rst_n & is_idle_c & ~instr_req_c & int_pend_q;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sp_q       <= SP_RESET;
         pc_lat_q   <= 8'h00;
         tgt_q      <= 8'h00;
         rti_q      <= 1'b0;
         int_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         pc_lat_q   <= pc_lat_d;
         tgt_q      <= tgt_d;
         rti_q      <= rti_d;
         int_pend_q <= int_pend_d;
         err_q      <= err_d;
      end
   end

   // Next state, stack pointer movement and request latching.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      pc_lat_d   = pc_lat_q;
      tgt_d      = tgt_q;
      rti_d      = rti_q;
      err_d      = err_q;
      int_pend_d = int_pend_q | INTR;

      unique case (state_q)
         IDLE: begin
            if (Rti_Req) begin
               state_d = POP_FL_RD;
               rti_d   = 1'b1;
            end else if (Ret_Req) begin
               state_d = POP_PC_RD;
               rti_d   = 1'b0;
            end else if (Call_Req) begin
               state_d  = CALL_PUSH;
               pc_lat_d = PC_Next;
               tgt_d    = Call_Target;
            end else if (accept_int_c) begin
               state_d    = INT_PUSH_PC;
               pc_lat_d   = PC_Next;
               int_pend_d = 1'b0;
            end
         end
         CALL_PUSH, INT_PUSH_PC, INT_PUSH_FL: begin
            sp_d  = sp_q - 8'd1;
            err_d = err_q | (sp_q == 8'h00);
            unique case (state_q)
               INT_PUSH_PC: state_d = INT_PUSH_FL;
               INT_PUSH_FL: state_d = INT_VEC_RD;
               default:     state_d = IDLE;
            endcase
         end
         INT_VEC_RD: state_d = INT_VEC_LD;
         POP_FL_RD, POP_PC_RD: begin
            sp_d    = sp_q + 8'd1;
            err_d   = err_q | (sp_q == 8'hFF);
            state_d = (state_q == POP_FL_RD) ? POP_PC_RD : POP_PC_LD;
         end
         INT_VEC_LD, POP_PC_LD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore output decode; only Stall and Int_Ack also react to the accepting IDLE cycle.
   always_comb begin
      Mem_Addr    = 8'h00;
      Mem_Wdata   = 8'h00;
      Mem_Rd      = 1'b0;
      Mem_Wr      = 1'b0;
      PC_Load     = 1'b0;
      PC_Value    = 8'h00;
      Flags_Load  = 1'b0;
      Flags_Value = 4'h0;
      Stall       = ~is_idle_c | accept_c;
      Int_Ack     = accept_int_c;

      unique case (state_q)
         CALL_PUSH: begin
            Mem_Wr    = 1'b1;
            Mem_Addr  = sp_q;
            Mem_Wdata = pc_lat_q;
            PC_Load   = 1'b1;
            PC_Value  = tgt_q;
         end
         INT_PUSH_PC: begin
            Mem_Wr    = 1'b1;
            Mem_Addr  = sp_q;
            Mem_Wdata = pc_lat_q;
         end
         INT_PUSH_FL: begin
            Mem_Wr    = 1'b1;
            Mem_Addr  = sp_q;
            Mem_Wdata = {4'b0000, Flags};
         end
         INT_VEC_RD: begin
            Mem_Rd   = 1'b1;
            Mem_Addr = INT_VECTOR;
         end
         POP_FL_RD: begin
            Mem_Rd   = 1'b1;
            Mem_Addr = sp_q + 8'd1;
         end
         POP_PC_RD: begin
            Mem_Rd      = 1'b1;
            Mem_Addr    = sp_q + 8'd1;
            Flags_Load  = rti_q;
            Flags_Value = rti_q ? Mem_Rdata[3:0] : 4'h0;
         end
         INT_VEC_LD, POP_PC_LD: begin
            PC_Load  = 1'b1;
            PC_Value = Mem_Rdata;
         end
         default: ;
      endcase
   end

   assign SP_Value  = sp_q;
   assign Stack_Err = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer: a transaction-level model expands each accepted
// request into its expected per-cycle output trace, checked against the DUT every cycle.
module tb_stack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       INTR, Call_Req, Ret_Req, Rti_Req;
   logic [7:0] Call_Target, PC_Next;
   logic [3:0] Flags;
   logic [7:0] Mem_Rdata;
   logic [7:0] Mem_Addr, Mem_Wdata, PC_Value, SP_Value;
   logic       Mem_Rd, Mem_Wr, PC_Load, Flags_Load, Stall, Int_Ack, Stack_Err;
   logic [3:0] Flags_Value;

   stack_sequencer #(.SP_RESET(8'hFF), .INT_VECTOR(8'h01)) dut (
      .clk(clk), .rst_n(rst_n), .INTR(INTR), .Call_Req(Call_Req), .Ret_Req(Ret_Req),
      .Rti_Req(Rti_Req), .Call_Target(Call_Target), .PC_Next(PC_Next), .Flags(Flags),
      .Mem_Rdata(Mem_Rdata), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_Rd(Mem_Rd),
      .Mem_Wr(Mem_Wr), .PC_Load(PC_Load), .PC_Value(PC_Value), .Flags_Load(Flags_Load),
      .Flags_Value(Flags_Value), .Stall(Stall), .Int_Ack(Int_Ack), .SP_Value(SP_Value),
      .Stack_Err(Stack_Err)
   );

   always #5 clk = ~clk;

   // Data memory with one-cycle read latency; the bench can preload it through its own port.
   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_a, tb_d;
   always @(posedge clk) begin
      if (tb_we) mem[tb_a] <= tb_d;
      else if (Mem_Wr) mem[Mem_Addr] <= Mem_Wdata;
      if (Mem_Rd) Mem_Rdata <= mem[Mem_Addr];
   end

   logic [63:0] act;
   assign act = {21'd0, Stall, Int_Ack, Mem_Rd, Mem_Wr, PC_Load, Flags_Load, Mem_Addr,
                 Mem_Wdata, PC_Value, Flags_Value, SP_Value, Stack_Err};

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [7:0]  ref_mem [256];
   logic [7:0]  m_sp;
   logic        m_err;
   logic        m_pend;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic stall, ack, rd, wr, pcl, fll,
                                      input logic [7:0] addr, wdata, pcv,
                                      input logic [3:0] flv, input logic [7:0] sp,
                                      input logic err);
      return {21'd0, stall, ack, rd, wr, pcl, fll, addr, wdata, pcv, flv, sp, err};
   endfunction

   function automatic logic [63:0] idle_vec();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, m_sp, m_err);
   endfunction

   // CALL: one push of the return address with the target loaded in the same cycle.
   function automatic logic [63:0] build_call(input logic [7:0] tgt, pcn);
      logic [63:0] v0;
      v0 = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, m_sp, m_err);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_sp, pcn, tgt, '0, m_sp, m_err));
      ref_mem[m_sp] = pcn;
      m_err = m_err | (m_sp == 8'h00);
      m_sp  = m_sp - 8'd1;
      return v0;
   endfunction

   // Interrupt: push PC, push flags, read vector, load PC.
   function automatic logic [63:0] build_int(input logic [7:0] pcn, input logic [3:0] fl);
      logic [63:0] v0;
      v0 = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, m_sp, m_err);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] d;
         d = (k == 0) ? pcn : {4'h0, fl};
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_sp, d, '0, '0, m_sp, m_err));
         ref_mem[m_sp] = d;
         m_err = m_err | (m_sp == 8'h00);
         m_sp  = m_sp - 8'd1;
      end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, '0, '0, '0, m_sp, m_err));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, ref_mem[1], '0, m_sp, m_err));
      return v0;
   endfunction

   // RET pops the PC only; RTI pops flags first, restoring them as the PC read goes out.
   function automatic logic [63:0] build_pop(input logic rti);
      logic [63:0] v0;
      logic [3:0]  flv;
      logic [7:0]  pcv;
      v0  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, m_sp, m_err);
      flv = 4'h0;
      if (rti) begin
         exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_sp + 8'd1, '0, '0, '0, m_sp, m_err));
         flv   = ref_mem[m_sp + 8'd1][3:0];
         m_err = m_err | (m_sp == 8'hFF);
         m_sp  = m_sp + 8'd1;
      end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rti, m_sp + 8'd1, '0, '0, flv, m_sp, m_err));
      pcv   = ref_mem[m_sp + 8'd1];
      m_err = m_err | (m_sp == 8'hFF);
      m_sp  = m_sp + 8'd1;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, pcv, '0, m_sp, m_err));
      return v0;
   endfunction

   // One clock: drive inputs, predict, compare mid-cycle, then advance the interrupt model.
   task automatic cycle(input string tag, input logic rti, ret, call, intr,
                        input logic [7:0] tgt, pcn, input logic rst_now);
      logic [63:0] e;
      logic        acc_int;
      rst_n = ~rst_now;
      Rti_Req = rti; Ret_Req = ret; Call_Req = call; INTR = intr;
      Call_Target = tgt; PC_Next = pcn;
      acc_int = 1'b0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else if (rst_now)      e = idle_vec();
      else if (rti)          e = build_pop(1'b1);
      else if (ret)          e = build_pop(1'b0);
      else if (call)         e = build_call(tgt, pcn);
      else if (m_pend) begin
         e = build_int(pcn, Flags);
         acc_int = 1'b1;
      end else e = idle_vec();
      @(negedge clk);
      check(tag, act, e);
      @(posedge clk);
      #1;
      if (rst_now) begin
         exp_q.delete();
         m_sp = 8'hFF; m_err = 1'b0; m_pend = 1'b0;
      end else m_pend = acc_int ? 1'b0 : (m_pend | intr);
   endtask

   task automatic drain();
      while (exp_q.size() != 0)
         cycle("drain", 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
   endtask

   task automatic do_reset();
      cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; INTR = 1'b0; Call_Req = 1'b0; Ret_Req = 1'b0; Rti_Req = 1'b0;
      Call_Target = 8'h00; PC_Next = 8'h00; Flags = 4'h0;
      tb_we = 1'b0; tb_a = 8'h00; tb_d = 8'h00;
      m_sp = 8'hFF; m_err = 1'b0; m_pend = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         tb_we = 1'b1; tb_a = 8'(i);
         tb_d  = (i == 1) ? 8'h80 : 8'($urandom);
         ref_mem[i] = tb_d;
         @(posedge clk); #1;
      end
      tb_we = 1'b0;
      do_reset();
      cycle("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

      cycle("call", 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h10, 1'b0);
      drain();
      check("mem_ff_call", 64'(mem[8'hFF]), 64'h10);
      cycle("ret", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 1'b0);
      drain();

      Flags = 4'b1010;
      cycle("intr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0);
      cycle("int_acc", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0);
      drain();
      check("mem_ff_int", 64'(mem[8'hFF]), 64'h22);
      check("mem_fe_int", 64'(mem[8'hFE]), 64'h0A);
      Flags = 4'b0000;
      cycle("rti", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0);
      drain();

      cycle("call_int", 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h33, 1'b0);
      cycle("call_push", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h56, 1'b0);
      cycle("int_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55, 1'b0);
      drain();
      check("mem_ff_ci", 64'(mem[8'hFF]), 64'h33);
      check("mem_fe_ci", 64'(mem[8'hFE]), 64'h55);
      cycle("rti2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();
      cycle("ret2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();

      cycle("intr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h66, 1'b0);
      cycle("int_acc2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h66, 1'b0);
      cycle("int_pc", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h67, 1'b0);
      cycle("rst_in_fl", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h68, 1'b1);
      cycle("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h69, 1'b0);

      cycle("ret_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();
      check("err_pop", 64'(Stack_Err), 64'h1);
      check("sp_pop", 64'(SP_Value), 64'h00);
      do_reset();
      for (int i = 0; i < 255; i++) begin
         cycle("call_fill", 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
         drain();
      end
      check("err_clear", 64'(Stack_Err), 64'h0);
      cycle("call_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
      drain();
      check("err_push", 64'(Stack_Err), 64'h1);
      check("sp_push", 64'(SP_Value), 64'hFF);
      do_reset();

      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0) Flags = 4'($urandom);
         cycle("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
               8'($urandom), 8'($urandom), 1'b0);
      end
      drain();
      cycle("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
